// File: rtl/seq_mult_hs_if.sv
// seq_mult_hs_if: operand/product handshake bundle for seq_mult_hs.
// Revision: 1.0. The sgn signal exists only when SEQ_MULT_SIGNED_EN is defined.
`default_nettype none

interface seq_mult_hs_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 sgn;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;

  modport master (
    output in_valid, a, b,
`ifdef SEQ_MULT_SIGNED_EN
    output sgn,
`endif
    input  in_ready, out_valid, p, busy,
    output out_ready
  );

  modport slave (
    input  in_valid, a, b,
`ifdef SEQ_MULT_SIGNED_EN
    input  sgn,
`endif
    output in_ready, out_valid, p, busy,
    input  out_ready
  );
endinterface

`default_nettype wire

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready in and out.
// Revision: 1.0. Define SEQ_MULT_SIGNED_EN to add the sgn port (two's complement operands).
`default_nettype none

module seq_mult_hs #(
  parameter int WIDTH = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  seq_mult_hs_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH-1:0]   w_opb;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;
  logic w_neg;

  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  always_comb begin
    w_neg = 1'b0;
    w_opa = bus.a;
    w_opb = bus.b;
    if (bus.sgn) begin
      w_neg = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      if (bus.a[WIDTH-1]) w_opa = -bus.a;
      if (bus.b[WIDTH-1]) w_opb = -bus.b;
    end
  end
`else
  assign w_opa = bus.a;
  assign w_opb = bus.b;
`endif

  assign w_sum  = {1'b0, r_acc} + (r_mplr[0] ? r_mcand : {(WIDTH+1){1'b0}});
  assign w_prod = {w_sum, r_mplr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_p     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      r_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mcand <= {1'b0, w_opa};
            r_mplr  <= w_opb;
            r_acc   <= '0;
            r_cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            r_neg   <= w_neg;
`endif
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc  <= w_sum[WIDTH:1];
          r_mplr <= {w_sum[0], r_mplr[WIDTH-1:1]};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SEQ_MULT_SIGNED_EN
            r_p <= r_neg ? -w_prod : w_prod;
`else
            r_p <= w_prod;
`endif
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_BUSY);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.p         = r_p;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: directed vector table plus handshake corner sequences for seq_mult_hs.
// Revision: 1.0. Signed vectors are added when SEQ_MULT_SIGNED_EN is defined.
`default_nettype none

module tb_seq_mult_hs;
  localparam int W = 4;

  logic clk;
  logic rst;

  seq_mult_hs_if #(.WIDTH(W)) bus ();

  seq_mult_hs #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp;
    int             hold;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int ba[3] = '{2, 12, 1};
  int bb[3] = '{3, 12, 15};
  int be[3] = '{6, 144, 15};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int edges;
    bus.a = v.a;
    bus.b = v.b;
`ifdef SEQ_MULT_SIGNED_EN
    bus.sgn = v.sgn;
`endif
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    check({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a = ~v.a;
    bus.b = v.b + 4'd5;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      check({tag, ".busy"}, 64'({bus.busy, bus.in_ready}), 64'b10);
      bus.in_valid = 1'b1;
      tick();
      edges++;
    end
    check({tag, ".latency"}, 64'(edges), 64'(W + 1));
    check({tag, ".p"}, 64'(bus.p), 64'(v.exp));
    repeat (v.hold) begin
      tick();
      check({tag, ".hold"}, 64'({bus.out_valid, bus.in_ready, bus.busy, bus.p}),
            64'({1'b1, 1'b0, 1'b0, v.exp}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".release"}, 64'({bus.out_valid, bus.in_ready, bus.p}),
          64'({1'b0, 1'b1, v.exp}));
  endtask

  initial begin
    int idx, got, last, cyc;
    bit acc_now, seen;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef SEQ_MULT_SIGNED_EN
    bus.sgn = 1'b0;
`endif

    vecs.push_back('{4'd15, 4'd15, 1'b0, 8'd225, 0});
    vecs.push_back('{4'd0,  4'd9,  1'b0, 8'd0,   0});
    vecs.push_back('{4'd9,  4'd0,  1'b0, 8'd0,   0});
    vecs.push_back('{4'd13, 4'd11, 1'b0, 8'd143, 10});
    vecs.push_back('{4'd1,  4'd1,  1'b0, 8'd1,   0});
    vecs.push_back('{4'd8,  4'd2,  1'b0, 8'd16,  2});
`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{4'h8, 4'h8, 1'b1, 8'h40, 0});
    vecs.push_back('{4'h8, 4'h7, 1'b1, 8'hC8, 0});
    vecs.push_back('{4'hF, 4'h1, 1'b1, 8'hFF, 0});
    vecs.push_back('{4'h8, 4'h8, 1'b0, 8'h40, 0});
`endif

    repeat (2) tick();
    check("reset", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.p}), 64'({3'b100, 8'd0}));
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Abort mid-iteration: reset lands two cycles after the accept edge.
    bus.a = 4'd7;
    bus.b = 4'd6;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.state", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.p}), 64'({3'b100, 8'd0}));
    seen = 1'b0;
    repeat (8) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    check("abort.no_out_valid", 64'(seen), 64'd0);
    run_op('{4'd3, 4'd5, 1'b0, 8'd15, 0}, "after_abort");

    // Back-to-back with in_valid and out_ready held high.
    idx = 0; got = 0; last = 0; cyc = 0;
`ifdef SEQ_MULT_SIGNED_EN
    bus.sgn = 1'b0;
`endif
    bus.a = 4'(ba[0]);
    bus.b = 4'(bb[0]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (got < 3 && cyc < 100) begin
      acc_now = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        check($sformatf("b2b.p%0d", got), 64'(bus.p), 64'(be[got]));
        if (got > 0) check($sformatf("b2b.gap%0d", got), 64'(cyc - last), 64'(W + 2));
        last = cyc;
        got++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        idx++;
        if (idx < 3) begin
          bus.a = 4'(ba[idx]);
          bus.b = 4'(bb[idx]);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("b2b.count", 64'(got), 64'd3);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
